system_memory_v4: RTL and testbench

Parametrised grid state store for the Conway engine. It holds a WIDTH×HEIGHT cell grid with three sources of updates: multi-lane serial load from the host, parallel capture of the next generation from the compute core, and multi-lane serial read-out. Serial load and read-out use valid/ready handshakes, and the block counts generations. It sits between the host serial link and the compute array.

---
 rtl/system_memory_v4.sv | 145 ++++++++++++++
 tb/tb_system_memory_v4.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/system_memory_v4.sv
// Grid state store for the Conway engine: host serial load, parallel capture
// of the next generation, and handshaked serial read-out with a generation count.
module system_memory_v4 #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned HEIGHT    = 8,
    parameter int unsigned LANES     = 1,
    parameter int unsigned GEN_WIDTH = 16
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [WIDTH*HEIGHT-1:0]     GRID_IN,
    input  logic [LANES-1:0]            SERIAL_IN,
    input  logic                        SERIAL_IN_VALID,
    input  logic                        LOAD_MODE,
    input  logic                        RUN_MODE,
    input  logic                        OUTPUT_MODE,
    input  logic                        SERIAL_OUT_READY,
    output logic [WIDTH*HEIGHT-1:0]     SYSTEM_MEM_OUT,
    output logic [LANES-1:0]            SERIAL_OUT,
    output logic                        SERIAL_OUT_VALID,
    output logic                        LOAD_DONE,
    output logic                        OUTPUT_DONE,
    output logic [GEN_WIDTH-1:0]        GENERATION
);

    localparam int unsigned GRID_SIZE = WIDTH * HEIGHT;
    localparam int unsigned BEATS     = GRID_SIZE / LANES;
    localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        OUT_IDLE  = 2'd0,
        OUT_SHIFT = 2'd1,
        OUT_DONE  = 2'd2
    } out_state_t;

    out_state_t               r_state,       w_state_n;
    logic [GRID_SIZE-1:0]     r_mem,         w_mem_n;
    logic [GRID_SIZE-1:0]     r_shadow,      w_shadow_n;
    logic [CNT_W-1:0]         r_load_cnt,    w_load_cnt_n;
    logic [CNT_W-1:0]         r_out_cnt,     w_out_cnt_n;
    logic [GEN_WIDTH-1:0]     r_gen,         w_gen_n;
    logic                     r_out_valid,   w_out_valid_n;
    logic                     r_load_done,   w_load_done_n;
    logic                     r_output_done, w_output_done_n;

    // State registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= OUT_IDLE;
            r_mem         <= '0;
            r_shadow      <= '0;
            r_load_cnt    <= '0;
            r_out_cnt     <= '0;
            r_gen         <= '0;
            r_out_valid   <= 1'b0;
            r_load_done   <= 1'b0;
            r_output_done <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_mem         <= w_mem_n;
            r_shadow      <= w_shadow_n;
            r_load_cnt    <= w_load_cnt_n;
            r_out_cnt     <= w_out_cnt_n;
            r_gen         <= w_gen_n;
            r_out_valid   <= w_out_valid_n;
            r_load_done   <= w_load_done_n;
            r_output_done <= w_output_done_n;
        end
    end

    // Mode arbitration (RUN > LOAD > OUTPUT > idle) and read-out FSM
    always_comb begin
        w_state_n       = r_state;
        w_mem_n         = r_mem;
        w_shadow_n      = r_shadow;
        w_load_cnt_n    = r_load_cnt;
        w_out_cnt_n     = r_out_cnt;
        w_gen_n         = r_gen;
        w_out_valid_n   = r_out_valid;
        w_load_done_n   = 1'b0;
        w_output_done_n = 1'b0;

        if (RUN_MODE) begin
            w_mem_n       = GRID_IN;
            w_gen_n       = r_gen + GEN_WIDTH'(1);
            w_load_cnt_n  = '0;
            w_state_n     = OUT_IDLE;
            w_out_valid_n = 1'b0;
        end else if (LOAD_MODE) begin
            if (SERIAL_IN_VALID) begin
                // Truncating the concatenation keeps the low GRID_SIZE bits
                w_mem_n = GRID_SIZE'({r_mem, SERIAL_IN});
                if (r_load_cnt == LAST_BEAT) begin
                    w_load_cnt_n  = '0;
                    w_load_done_n = 1'b1;
                    w_gen_n       = '0;
                end else begin
                    w_load_cnt_n = r_load_cnt + CNT_W'(1);
                end
            end
            w_state_n     = OUT_IDLE;
            w_out_valid_n = 1'b0;
        end else if (OUTPUT_MODE) begin
            case (r_state)
                OUT_IDLE: begin
                    w_shadow_n    = r_mem;
                    w_out_cnt_n   = '0;
                    w_out_valid_n = 1'b1;
                    w_state_n     = OUT_SHIFT;
                end
                OUT_SHIFT: begin
                    if (r_out_valid && SERIAL_OUT_READY) begin
                        if (r_out_cnt == LAST_BEAT) begin
                            w_out_valid_n   = 1'b0;
                            w_output_done_n = 1'b1;
                            w_state_n       = OUT_DONE;
                        end else begin
                            w_shadow_n  = r_shadow << LANES;
                            w_out_cnt_n = r_out_cnt + CNT_W'(1);
                        end
                    end
                end
                OUT_DONE: begin
                    w_state_n = OUT_DONE;
                end
                default: begin
                    w_state_n     = OUT_IDLE;
                    w_out_valid_n = 1'b0;
                end
            endcase
        end else begin
            w_state_n     = OUT_IDLE;
            w_out_valid_n = 1'b0;
        end
    end

    assign SYSTEM_MEM_OUT   = r_mem;
    assign SERIAL_OUT       = r_out_valid ? r_shadow[GRID_SIZE-1 -: LANES] : '0;
    assign SERIAL_OUT_VALID = r_out_valid;
    assign LOAD_DONE        = r_load_done;
    assign OUTPUT_DONE      = r_output_done;
    assign GENERATION       = r_gen;

endmodule

// File: tb/tb_system_memory_v4.sv
// Directed self-checking bench for system_memory_v4 with a 4x2 grid, 2 lanes.
module tb_system_memory_v4;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] GRID_IN;
    logic [1:0] SERIAL_IN;
    logic       SERIAL_IN_VALID;
    logic       LOAD_MODE;
    logic       RUN_MODE;
    logic       OUTPUT_MODE;
    logic       SERIAL_OUT_READY;
    logic [7:0] SYSTEM_MEM_OUT;
    logic [1:0] SERIAL_OUT;
    logic       SERIAL_OUT_VALID;
    logic       LOAD_DONE;
    logic       OUTPUT_DONE;
    logic [15:0] GENERATION;

    int checks = 0;
    int errors = 0;

    system_memory_v4 #(.WIDTH(4), .HEIGHT(2), .LANES(2), .GEN_WIDTH(16)) dut (
        .CLK(CLK), .RESET(RESET), .GRID_IN(GRID_IN), .SERIAL_IN(SERIAL_IN),
        .SERIAL_IN_VALID(SERIAL_IN_VALID), .LOAD_MODE(LOAD_MODE), .RUN_MODE(RUN_MODE),
        .OUTPUT_MODE(OUTPUT_MODE), .SERIAL_OUT_READY(SERIAL_OUT_READY),
        .SYSTEM_MEM_OUT(SYSTEM_MEM_OUT), .SERIAL_OUT(SERIAL_OUT),
        .SERIAL_OUT_VALID(SERIAL_OUT_VALID), .LOAD_DONE(LOAD_DONE),
        .OUTPUT_DONE(OUTPUT_DONE), .GENERATION(GENERATION)
    );

    always #5 CLK = ~CLK;

    // Inputs change 1 time unit after the rising edge; outputs are read there too
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; GRID_IN = 8'hFF; SERIAL_IN = 2'b11; SERIAL_IN_VALID = 1'b1;
        LOAD_MODE = 1'b0; RUN_MODE = 1'b0; OUTPUT_MODE = 1'b0; SERIAL_OUT_READY = 1'b0;
        step();
        checks++;
        if ({SYSTEM_MEM_OUT, GENERATION, SERIAL_OUT_VALID, SERIAL_OUT, LOAD_DONE, OUTPUT_DONE} !== 29'd0) begin
            errors++; $display("FAIL reset_state mem=%h gen=%0d v=%b so=%b ld=%b od=%b expected all zero",
                               SYSTEM_MEM_OUT, GENERATION, SERIAL_OUT_VALID, SERIAL_OUT, LOAD_DONE, OUTPUT_DONE);
        end
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({SYSTEM_MEM_OUT, GENERATION, SERIAL_OUT_VALID, LOAD_DONE, OUTPUT_DONE} !== 27'd0) begin
                errors++; $display("FAIL idle_hold[%0d] mem=%h gen=%0d v=%b ld=%b od=%b expected all zero",
                                   i, SYSTEM_MEM_OUT, GENERATION, SERIAL_OUT_VALID, LOAD_DONE, OUTPUT_DONE);
            end
        end
    endtask

    task automatic test_load_stall();
        logic [1:0] beat_v [5];
        logic       vld_v  [5];
        logic [7:0] mem_v  [5];
        logic       done_v [5];
        beat_v = '{2'b10, 2'b11, 2'b11, 2'b00, 2'b01};
        vld_v  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        mem_v  = '{8'h02, 8'h0B, 8'h0B, 8'h2C, 8'hB1};
        done_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        LOAD_MODE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            SERIAL_IN = beat_v[i]; SERIAL_IN_VALID = vld_v[i];
            step();
            checks++;
            if (SYSTEM_MEM_OUT !== mem_v[i] || LOAD_DONE !== done_v[i]) begin
                errors++; $display("FAIL load_beat[%0d] mem=%h ld=%b expected mem=%h ld=%b",
                                   i, SYSTEM_MEM_OUT, LOAD_DONE, mem_v[i], done_v[i]);
            end
        end
        checks++;
        if (GENERATION !== 16'd0) begin
            errors++; $display("FAIL load_gen gen=%0d expected 0", GENERATION);
        end
        LOAD_MODE = 1'b0; SERIAL_IN_VALID = 1'b0;
        step();
        checks++;
        if (LOAD_DONE !== 1'b0 || SYSTEM_MEM_OUT !== 8'hB1) begin
            errors++; $display("FAIL load_done_pulse ld=%b mem=%h expected ld=0 mem=b1", LOAD_DONE, SYSTEM_MEM_OUT);
        end
    endtask

    task automatic test_run_priority();
        logic [1:0] beat_v [4];
        beat_v = '{2'b10, 2'b11, 2'b00, 2'b01};
        RUN_MODE = 1'b1; LOAD_MODE = 1'b1; OUTPUT_MODE = 1'b1; SERIAL_IN_VALID = 1'b1;
        SERIAL_IN = 2'b11; GRID_IN = 8'h5A;
        step();
        checks++;
        if (SYSTEM_MEM_OUT !== 8'h5A || GENERATION !== 16'd1 || SERIAL_OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL run_first mem=%h gen=%0d v=%b expected mem=5a gen=1 v=0",
                               SYSTEM_MEM_OUT, GENERATION, SERIAL_OUT_VALID);
        end
        GRID_IN = 8'hC3;
        step();
        checks++;
        if (SYSTEM_MEM_OUT !== 8'hC3 || GENERATION !== 16'd2) begin
            errors++; $display("FAIL run_second mem=%h gen=%0d expected mem=c3 gen=2", SYSTEM_MEM_OUT, GENERATION);
        end
        RUN_MODE = 1'b0; OUTPUT_MODE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            SERIAL_IN = beat_v[i];
            step();
            if (i == 2) begin
                checks++;
                if (GENERATION !== 16'd2 || LOAD_DONE !== 1'b0) begin
                    errors++; $display("FAIL gen_before_final gen=%0d ld=%b expected gen=2 ld=0", GENERATION, LOAD_DONE);
                end
            end
        end
        checks++;
        if (SYSTEM_MEM_OUT !== 8'hB1 || GENERATION !== 16'd0 || LOAD_DONE !== 1'b1) begin
            errors++; $display("FAIL load_clears_gen mem=%h gen=%0d ld=%b expected mem=b1 gen=0 ld=1",
                               SYSTEM_MEM_OUT, GENERATION, LOAD_DONE);
        end
        LOAD_MODE = 1'b0; SERIAL_IN_VALID = 1'b0;
        step();
    endtask

    task automatic test_readout_backpressure();
        logic       rdy_v [6];
        logic [1:0] so_v  [6];
        logic       vl_v  [6];
        logic       od_v  [6];
        rdy_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        so_v  = '{2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b00};
        vl_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        od_v  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        OUTPUT_MODE = 1'b1;
        for (int i = 0; i < 6; i++) begin
            SERIAL_OUT_READY = rdy_v[i];
            step();
            checks++;
            if (SERIAL_OUT !== so_v[i] || SERIAL_OUT_VALID !== vl_v[i] || OUTPUT_DONE !== od_v[i]
                || SYSTEM_MEM_OUT !== 8'hB1) begin
                errors++; $display("FAIL readout[%0d] so=%b v=%b od=%b mem=%h expected so=%b v=%b od=%b mem=b1",
                                   i, SERIAL_OUT, SERIAL_OUT_VALID, OUTPUT_DONE, SYSTEM_MEM_OUT,
                                   so_v[i], vl_v[i], od_v[i]);
            end
        end
        step();
        checks++;
        if (OUTPUT_DONE !== 1'b0 || SERIAL_OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL readout_after od=%b v=%b expected od=0 v=0", OUTPUT_DONE, SERIAL_OUT_VALID);
        end
        OUTPUT_MODE = 1'b0;
        step();
    endtask

    task automatic test_readout_abort();
        SERIAL_OUT_READY = 1'b1; OUTPUT_MODE = 1'b1;
        step(); step(); step();
        checks++;
        if (SERIAL_OUT !== 2'b00 || SERIAL_OUT_VALID !== 1'b1) begin
            errors++; $display("FAIL abort_pre so=%b v=%b expected so=00 v=1", SERIAL_OUT, SERIAL_OUT_VALID);
        end
        OUTPUT_MODE = 1'b0;
        step();
        checks++;
        if (SERIAL_OUT_VALID !== 1'b0 || OUTPUT_DONE !== 1'b0 || SERIAL_OUT !== 2'b00) begin
            errors++; $display("FAIL abort_drop v=%b od=%b so=%b expected v=0 od=0 so=00",
                               SERIAL_OUT_VALID, OUTPUT_DONE, SERIAL_OUT);
        end
        OUTPUT_MODE = 1'b1;
        step();
        checks++;
        if (SERIAL_OUT !== 2'b10 || SERIAL_OUT_VALID !== 1'b1) begin
            errors++; $display("FAIL abort_restart so=%b v=%b expected so=10 v=1", SERIAL_OUT, SERIAL_OUT_VALID);
        end
        step();
        RUN_MODE = 1'b1; GRID_IN = 8'hB1;
        step();
        checks++;
        if (SERIAL_OUT_VALID !== 1'b0 || OUTPUT_DONE !== 1'b0 || GENERATION !== 16'd1) begin
            errors++; $display("FAIL run_abort v=%b od=%b gen=%0d expected v=0 od=0 gen=1",
                               SERIAL_OUT_VALID, OUTPUT_DONE, GENERATION);
        end
        RUN_MODE = 1'b0; OUTPUT_MODE = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_load();
        LOAD_MODE = 1'b1; SERIAL_IN_VALID = 1'b1; SERIAL_IN = 2'b11;
        step(); step();
        checks++;
        if (SYSTEM_MEM_OUT !== 8'h1F) begin
            errors++; $display("FAIL partial_load mem=%h expected 1f", SYSTEM_MEM_OUT);
        end
        RESET = 1'b1;
        step();
        checks++;
        if (SYSTEM_MEM_OUT !== 8'h00 || GENERATION !== 16'd0) begin
            errors++; $display("FAIL mid_load_reset mem=%h gen=%0d expected mem=00 gen=0", SYSTEM_MEM_OUT, GENERATION);
        end
        RESET = 1'b0; SERIAL_IN = 2'b01;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (LOAD_DONE !== (i == 3)) begin
                errors++; $display("FAIL reload_done[%0d] ld=%b expected %b", i, LOAD_DONE, (i == 3));
            end
        end
        checks++;
        if (SYSTEM_MEM_OUT !== 8'h55) begin
            errors++; $display("FAIL reload_mem mem=%h expected 55", SYSTEM_MEM_OUT);
        end
        LOAD_MODE = 1'b0; SERIAL_IN_VALID = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_load_stall();
        test_run_priority();
        test_readout_backpressure();
        test_readout_abort();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
